// File: rtl/bin_fcl_seq.sv
// Feed/capture sequencer in front of the binary fully-connected PE array.
// Optional stall counter port stall_cnt enabled by FCL_SEQ_PERFCNT_EN.
module bin_fcl_seq #(
  parameter int N_IN    = 256,
  parameter int N_OUT   = 64,
  parameter int PAR     = 8,
  parameter int SHIFT_W = 5,
  localparam int NT     = N_OUT / PAR,
  localparam int AW     = $clog2(N_IN),
  localparam int WAW    = $clog2(N_IN * NT),
  localparam int TW     = (NT > 1) ? $clog2(NT) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [SHIFT_W-1:0] shift_cfg,
  output logic               busy,
  output logic               done,
  output logic [AW-1:0]      act_addr,
  input  logic               act_rdata,
  output logic [WAW-1:0]     w_addr,
  input  logic [PAR-1:0]     w_rdata,
  output logic               pe_clr_n,
  output logic               pe_in,
  output logic [PAR-1:0]     pe_w,
  output logic [SHIFT_W-1:0] pe_shift,
  input  logic [PAR-1:0]     pe_out,
  output logic [PAR-1:0]     out_data,
  output logic [TW-1:0]      out_tile,
  output logic               out_valid,
  input  logic               out_ready
`ifdef FCL_SEQ_PERFCNT_EN
  ,
  output logic [31:0]        stall_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FEED,
    S_DRAIN,
    S_CAPT,
    S_HOLD,
    S_DONE
  } state_e;

  localparam logic [AW-1:0] K_LAST = AW'(N_IN - 1);
  localparam logic [TW-1:0] T_LAST = TW'(NT - 1);

  state_e             state_q, state_d;
  logic [AW-1:0]      k_q, k_d;
  logic [WAW-1:0]     w_q, w_d;
  logic [TW-1:0]      t_q, t_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic [PAR-1:0]     data_q, data_d;
  logic [TW-1:0]      tile_q, tile_d;
  logic               accept;

  assign accept = (state_q == S_IDLE) && start;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    w_d     = w_q;
    t_d     = t_q;
    shift_d = shift_q;
    data_d  = data_q;
    tile_d  = tile_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FEED;
          k_d     = '0;
          w_d     = '0;
          t_d     = '0;
          shift_d = shift_cfg;
        end
      end
      S_FEED: begin
        if (k_q == K_LAST) begin
          state_d = S_DRAIN;
        end else begin
          k_d = k_q + AW'(1);
          w_d = w_q + WAW'(1);
        end
      end
      S_DRAIN: state_d = S_CAPT;
      S_CAPT: begin
        state_d = S_HOLD;
        data_d  = pe_out;
        tile_d  = t_q;
      end
      S_HOLD: begin
        if (out_ready) begin
          if (t_q == T_LAST) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FEED;
            t_d     = t_q + TW'(1);
            k_d     = '0;
            w_d     = w_q + WAW'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

`ifdef FCL_SEQ_PERFCNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (accept) begin
      stall_d = '0;
    end else if (out_valid && !out_ready && (stall_q != '1)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      w_q     <= '0;
      t_q     <= '0;
      shift_q <= '0;
      data_q  <= '0;
      tile_q  <= '0;
`ifdef FCL_SEQ_PERFCNT_EN
      stall_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      w_q     <= w_d;
      t_q     <= t_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      tile_q  <= tile_d;
`ifdef FCL_SEQ_PERFCNT_EN
      stall_q <= stall_d;
`endif
    end
  end

  // product k is on the array one cycle after address k; only k=0 clears
  assign pe_clr_n  = (state_q == S_DRAIN) ||
                     ((state_q == S_FEED) && (k_q > AW'(1)));
  assign pe_in     = act_rdata;
  assign pe_w      = w_rdata;
  assign pe_shift  = shift_q;
  assign act_addr  = k_q;
  assign w_addr    = w_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign out_valid = (state_q == S_HOLD);
  assign out_data  = data_q;
  assign out_tile  = tile_q;

endmodule

// File: tb/tb_bin_fcl_seq.sv
// Directed bench for bin_fcl_seq: cycle table plus backpressure,
// mid-run reset and restart sequences.
module tb_bin_fcl_seq;

  localparam int N_IN = 4;
  localparam int N_OUT = 16;
  localparam int PAR = 8;
  localparam int SW = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [4:0] shift_cfg = '0;
  logic       busy, done;
  logic [1:0] act_addr;
  logic       act_rdata;
  logic [2:0] w_addr;
  logic [7:0] w_rdata;
  logic       pe_clr_n, pe_in;
  logic [7:0] pe_w;
  logic [4:0] pe_shift;
  logic [7:0] pe_out = '0;
  logic [7:0] out_data;
  logic [0:0] out_tile;
  logic       out_valid;
  logic       out_ready = 1'b1;
`ifdef FCL_SEQ_PERFCNT_EN
  logic [31:0] stall_cnt;
`endif

  bin_fcl_seq #(
    .N_IN(N_IN), .N_OUT(N_OUT), .PAR(PAR), .SHIFT_W(SW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .shift_cfg(shift_cfg),
    .busy(busy), .done(done),
    .act_addr(act_addr), .act_rdata(act_rdata),
    .w_addr(w_addr), .w_rdata(w_rdata),
    .pe_clr_n(pe_clr_n), .pe_in(pe_in), .pe_w(pe_w),
    .pe_shift(pe_shift), .pe_out(pe_out),
    .out_data(out_data), .out_tile(out_tile),
    .out_valid(out_valid), .out_ready(out_ready)
`ifdef FCL_SEQ_PERFCNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [3:0] act_bits;
  logic [7:0] w_mem [8];

  always @(posedge clk) begin
    act_rdata <= act_bits[act_addr];
    w_rdata   <= w_mem[w_addr];
  end

  int done_cnt = 0;
  always @(negedge clk) if (done === 1'b1) done_cnt++;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  typedef struct {
    logic       st;
    logic       rdy;
    logic [7:0] po;
    logic [4:0] sh;
    logic       bz;
    logic       dn;
    logic [1:0] aa;
    logic [2:0] wa;
    logic       clr;
    logic       vl;
    logic       tl;
    logic [7:0] dt;
    logic [4:0] ps;
  } vec_t;

  function automatic vec_t mk(logic st, logic rdy, logic [7:0] po,
      logic [4:0] sh, logic bz, logic dn, logic [1:0] aa,
      logic [2:0] wa, logic clr, logic vl, logic tl,
      logic [7:0] dt, logic [4:0] ps);
    vec_t v;
    v.st = st; v.rdy = rdy; v.po = po; v.sh = sh;
    v.bz = bz; v.dn = dn; v.aa = aa; v.wa = wa;
    v.clr = clr; v.vl = vl; v.tl = tl; v.dt = dt; v.ps = ps;
    return v;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  vec_t tv[18];
  logic [22:0] got_v, exp_v;
  logic [1:0] last_aa;
  logic [2:0] last_wa;
  int dc0;
  bit hit;

  initial begin
    act_bits = 4'b1011;
    for (int i = 0; i < 8; i++) w_mem[i] = 8'(8'h11 * i + 3);

    //         st rdy po    sh bz dn aa wa clr vl tl dt    ps
    tv[0]  = mk(1, 1, 8'h00, 3, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0);
    tv[1]  = mk(0, 1, 8'h00, 7, 1, 0, 0, 0, 0, 0, 0, 8'h00, 3);
    tv[2]  = mk(1, 1, 8'h00, 7, 1, 0, 1, 1, 0, 0, 0, 8'h00, 3);
    tv[3]  = mk(0, 1, 8'h00, 7, 1, 0, 2, 2, 1, 0, 0, 8'h00, 3);
    tv[4]  = mk(0, 1, 8'h00, 7, 1, 0, 3, 3, 1, 0, 0, 8'h00, 3);
    tv[5]  = mk(1, 1, 8'h00, 7, 1, 0, 3, 3, 1, 0, 0, 8'h00, 3);
    tv[6]  = mk(0, 1, 8'hA5, 7, 1, 0, 3, 3, 0, 0, 0, 8'h00, 3);
    tv[7]  = mk(0, 1, 8'h00, 7, 1, 0, 3, 3, 0, 1, 0, 8'hA5, 3);
    tv[8]  = mk(0, 1, 8'h00, 7, 1, 0, 0, 4, 0, 0, 0, 8'hA5, 3);
    tv[9]  = mk(0, 1, 8'h00, 7, 1, 0, 1, 5, 0, 0, 0, 8'hA5, 3);
    tv[10] = mk(0, 1, 8'h00, 7, 1, 0, 2, 6, 1, 0, 0, 8'hA5, 3);
    tv[11] = mk(0, 1, 8'h00, 7, 1, 0, 3, 7, 1, 0, 0, 8'hA5, 3);
    tv[12] = mk(0, 1, 8'h00, 7, 1, 0, 3, 7, 1, 0, 0, 8'hA5, 3);
    tv[13] = mk(0, 1, 8'h3C, 7, 1, 0, 3, 7, 0, 0, 0, 8'hA5, 3);
    tv[14] = mk(0, 1, 8'h00, 7, 1, 0, 3, 7, 0, 1, 1, 8'h3C, 3);
    tv[15] = mk(1, 1, 8'h00, 7, 1, 1, 3, 7, 0, 0, 1, 8'h3C, 3);
    tv[16] = mk(0, 1, 8'h00, 7, 0, 0, 3, 7, 0, 0, 1, 8'h3C, 3);
    tv[17] = mk(0, 1, 8'h00, 7, 0, 0, 3, 7, 0, 0, 1, 8'h3C, 3);

    // reset state
    repeat (3) cyc();
    @(negedge clk);
    chk("reset", {busy, done, out_valid, pe_clr_n, act_addr, w_addr,
                  out_data, out_tile, pe_shift},
        {1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 8'h00, 1'b0, 5'd0});
`ifdef FCL_SEQ_PERFCNT_EN
    chk("reset_stall", stall_cnt, 0);
`endif
    cyc();
    rst = 1'b1;

    // basic two-tile run, start pulses at 2, 5 and DONE ignored
    last_aa = '0;
    last_wa = '0;
    for (int i = 0; i < 18; i++) begin
      cyc();
      start = tv[i].st;
      out_ready = tv[i].rdy;
      pe_out = tv[i].po;
      shift_cfg = tv[i].sh;
      @(negedge clk);
      got_v = {busy, done, act_addr, w_addr, pe_clr_n, out_valid,
               out_tile, out_data, pe_shift};
      exp_v = {tv[i].bz, tv[i].dn, tv[i].aa, tv[i].wa, tv[i].clr,
               tv[i].vl, tv[i].tl, tv[i].dt, tv[i].ps};
      chk($sformatf("row%0d", i), 64'(got_v), 64'(exp_v));
      if (i > 0)
        chk($sformatf("pass%0d", i), {pe_in, pe_w},
            {act_bits[last_aa], w_mem[last_wa]});
      last_aa = act_addr;
      last_wa = w_addr;
    end
    cyc();
    chk("one_done", done_cnt, 1);

    // backpressure on tile 0, new shift value latched at this start
    start = 1'b1;
    shift_cfg = 5'd7;
    out_ready = 1'b0;
    pe_out = 8'h5A;
    cyc();
    start = 1'b0;
    shift_cfg = 5'd1;
    hit = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (out_valid) begin
        hit = 1;
        break;
      end
    end
    chk("bp_valid_seen", 64'(hit), 1);
    pe_out = 8'hFF;
    for (int j = 0; j < 10; j++) begin
      chk($sformatf("bp_hold%0d", j),
          {out_valid, out_data, out_tile, act_addr, w_addr, pe_shift},
          {1'b1, 8'h5A, 1'b0, 2'd3, 3'd3, 5'd7});
      if (j < 9) @(negedge clk);
    end
    cyc();
    out_ready = 1'b1;
    @(negedge clk);
`ifdef FCL_SEQ_PERFCNT_EN
    chk("stall_cnt", stall_cnt, 10);
`endif
    chk("bp_release", {out_valid, out_data}, {1'b1, 8'h5A});
    hit = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (out_valid) begin
        hit = 1;
        break;
      end
    end
    chk("bp_tile1", {64'(hit), out_tile, out_data},
        {64'd1, 1'b1, 8'hFF});
    dc0 = done_cnt;
    for (int j = 0; j < 20; j++) begin
      cyc();
      if (!busy) break;
    end
    chk("bp_done", done_cnt - dc0, 1);

    // reset asserted in cycle 3 of a run
    cyc();
    dc0 = done_cnt;
    start = 1'b1;
    shift_cfg = 5'd3;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("pre_rst_addr", act_addr, 2);
    cyc();
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst", {busy, done, out_valid, pe_clr_n, act_addr, w_addr,
                    pe_shift},
        {1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 5'd0});
    repeat (10) cyc();
    chk("rst_no_done", done_cnt - dc0, 0);

    // clean restart from tile 0
    start = 1'b1;
    cyc();
    start = 1'b0;
    @(negedge clk);
    chk("restart_addr", {busy, act_addr, w_addr, pe_shift},
        {1'b1, 2'd0, 3'd0, 5'd3});
    pe_out = 8'h66;
    hit = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (out_valid) begin
        hit = 1;
        break;
      end
    end
    chk("restart_tile0", {64'(hit), out_tile, out_data},
        {64'd1, 1'b0, 8'h66});
    for (int j = 0; j < 30; j++) begin
      cyc();
      if (!busy) break;
    end
    chk("restart_done", done_cnt - dc0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
